// File: rtl/ddr3_frame_reader.sv
// Consumer side of the ping-pong frame buffer: waits for the expected buffer to fill,
// reads the whole frame from DDR3 in fixed-length bursts and streams it into the pixel FIFO.
module ddr3_frame_reader #(
    parameter int DATA_W      = 128,
    parameter int BURST_LEN   = 32,
    parameter int FRAME_WORDS = 19200,
    parameter int FIFO_AW     = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              buffer0_empty,
    input  logic              buffer1_empty,
    input  logic [25:0]       buffer0_offset,
    input  logic [25:0]       buffer1_offset,
    output logic              clear_buffer0,
    output logic              clear_buffer1,
    output logic [25:0]       avm_address,
    output logic              avm_read,
    output logic [7:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic [FIFO_AW:0]  fifo_space,
    output logic              frame_start,
    output logic              cur_buffer,
    output logic              busy
);
    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam int BCW = $clog2(BURST_LEN) + 1;
    localparam int SPW = FIFO_AW + 1;
    localparam logic [WCW-1:0] FRAME_END   = WCW'(FRAME_WORDS);
    localparam logic [WCW-1:0] WORD_ONE    = WCW'(1);
    localparam logic [BCW-1:0] LAST_BEAT   = BCW'(BURST_LEN - 1);
    localparam logic [BCW-1:0] BEAT_ONE    = BCW'(1);
    localparam logic [SPW-1:0] BURST_SPACE = SPW'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic              cur_buffer_q, cur_buffer_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [25:0]       base_addr_q, base_addr_d;
    logic [25:0]       avm_address_q, avm_address_d;
    logic              avm_read_q, avm_read_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0] fifo_wr_data_q, fifo_wr_data_d;
    logic              frame_start_c;
    logic              sel_full;
    logic [25:0]       sel_offset;
    logic              space_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cur_buffer_q   <= 1'b0;
            word_cnt_q     <= '0;
            beat_cnt_q     <= '0;
            base_addr_q    <= '0;
            avm_address_q  <= '0;
            avm_read_q     <= 1'b0;
            fifo_wr_q      <= 1'b0;
            fifo_wr_data_q <= '0;
        end else begin
            state_q        <= state_d;
            cur_buffer_q   <= cur_buffer_d;
            word_cnt_q     <= word_cnt_d;
            beat_cnt_q     <= beat_cnt_d;
            base_addr_q    <= base_addr_d;
            avm_address_q  <= avm_address_d;
            avm_read_q     <= avm_read_d;
            fifo_wr_q      <= fifo_wr_d;
            fifo_wr_data_q <= fifo_wr_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cur_buffer_d   = cur_buffer_q;
        word_cnt_d     = word_cnt_q;
        beat_cnt_d     = beat_cnt_q;
        base_addr_d    = base_addr_q;
        avm_address_d  = avm_address_q;
        avm_read_d     = avm_read_q;
        fifo_wr_d      = 1'b0;
        fifo_wr_data_d = fifo_wr_data_q;
        frame_start_c  = 1'b0;
        sel_full       = cur_buffer_q ? ~buffer1_empty : ~buffer0_empty;
        sel_offset     = cur_buffer_q ? buffer1_offset : buffer0_offset;
        space_ok       = (fifo_space >= BURST_SPACE);

        case (state_q)
            IDLE: begin
                // Mid-frame the full flag is not re-checked; only FIFO room gates the next burst.
                if (space_ok && ((word_cnt_q != '0) || sel_full)) begin
                    state_d    = REQ;
                    avm_read_d = 1'b1;
                    if (word_cnt_q == '0) begin
                        frame_start_c = 1'b1;
                        base_addr_d   = sel_offset;
                        avm_address_d = sel_offset;
                    end else begin
                        avm_address_d = base_addr_q + 26'(word_cnt_q);
                    end
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (avm_readdatavalid) begin
                    fifo_wr_d      = 1'b1;
                    fifo_wr_data_d = avm_readdata;
                    word_cnt_d     = word_cnt_q + WORD_ONE;
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = (word_cnt_d < FRAME_END) ? IDLE : DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    end
                end
            end
            DONE: begin
                cur_buffer_d = ~cur_buffer_q;
                word_cnt_d   = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // frame_start is combinational, so it is masked while reset is held.
    assign frame_start    = frame_start_c & reset_n;
    assign clear_buffer0  = (state_q == DONE) && !cur_buffer_q;
    assign clear_buffer1  = (state_q == DONE) && cur_buffer_q;
    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_burstcount = 8'(BURST_LEN);
    assign fifo_wr        = fifo_wr_q;
    assign fifo_wr_data   = fifo_wr_data_q;
    assign cur_buffer     = cur_buffer_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Scoreboard bench for ddr3_frame_reader: a frame-level reference model queues the
// expected bursts, words, clears and frame starts; a monitor checks what the DUT emits.
module tb_ddr3_frame_reader;
    localparam int DW = 32;
    localparam int BL = 32;
    localparam int FW = 64;
    localparam int AW = 9;

    logic          clk, reset_n;
    logic          buffer0_empty, buffer1_empty;
    logic [25:0]   buffer0_offset, buffer1_offset;
    logic          clear_buffer0, clear_buffer1;
    logic [25:0]   avm_address;
    logic          avm_read;
    logic [7:0]    avm_burstcount;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          fifo_wr;
    logic [DW-1:0] fifo_wr_data;
    logic [AW:0]   fifo_space;
    logic          frame_start, cur_buffer, busy;

    ddr3_frame_reader #(.DATA_W(DW), .BURST_LEN(BL), .FRAME_WORDS(FW), .FIFO_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .buffer0_empty(buffer0_empty), .buffer1_empty(buffer1_empty),
        .buffer0_offset(buffer0_offset), .buffer1_offset(buffer1_offset),
        .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .fifo_space(fifo_space),
        .frame_start(frame_start), .cur_buffer(cur_buffer), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int wait_cfg = 0;
    int gap_cfg = 1;
    int wr_count = 0;
    int fill0_req = 0;
    int fill1_req = 0;
    logic ref_cur = 1'b0;

    logic [25:0]   exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [1:0]    exp_clear[$];
    logic          exp_fs[$];

    function automatic logic [DW-1:0] pat(input logic [25:0] a);
        logic [31:0] x;
        x = {6'b0, a};
        return (x * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected 0x%0h, nothing expected", name, act);
    endtask

    // Reference model: a whole frame from buffer b at word base off.
    task automatic push_frame(input logic b, input logic [25:0] off);
        exp_fs.push_back(b);
        for (int k = 0; k < FW / BL; k++) exp_addr.push_back(off + 26'(k * BL));
        for (int i = 0; i < FW; i++) exp_data.push_back(pat(off + 26'(i)));
        exp_clear.push_back(b ? 2'b10 : 2'b01);
        ref_cur = ~b;
    endtask

    // Flag producer: marks buffers full on request, empties a buffer one cycle after its clear.
    initial begin
        int f0a, f1a;
        logic p0, p1;
        f0a = 0; f1a = 0; p0 = 1'b0; p1 = 1'b0;
        buffer0_empty = 1'b1;
        buffer1_empty = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (p0) begin buffer0_empty = 1'b1; p0 = 1'b0; end
            if (p1) begin buffer1_empty = 1'b1; p1 = 1'b0; end
            if (clear_buffer0) p0 = 1'b1;
            if (clear_buffer1) p1 = 1'b1;
            if (fill0_req != f0a) begin buffer0_empty = 1'b0; f0a = fill0_req; end
            if (fill1_req != f1a) begin buffer1_empty = 1'b0; f1a = fill1_req; end
        end
    end

    // Avalon slave: wait_cfg waitrequest cycles per request, beats every gap_cfg cycles (0 = random).
    initial begin
        int s_beats, s_idx, s_gap, s_wait;
        logic s_acc, s_seen;
        logic [25:0] s_addr, s_acc_addr;
        s_beats = 0; s_idx = 0; s_gap = 0; s_wait = 0;
        s_acc = 1'b0; s_seen = 1'b0; s_addr = '0; s_acc_addr = '0;
        avm_waitrequest = 1'b1;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n) begin
                avm_waitrequest = 1'b1;
                avm_readdatavalid = 1'b0;
                s_beats = 0; s_acc = 1'b0; s_seen = 1'b0;
            end else begin
                if (s_acc) begin
                    s_addr = s_acc_addr; s_beats = BL; s_idx = 0; s_gap = 0; s_acc = 1'b0;
                end
                avm_readdatavalid = 1'b0;
                if (s_beats > 0) begin
                    if ((gap_cfg == 0) ? ($urandom_range(0, 1) == 1) : (s_gap == 0)) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = pat(s_addr + 26'(s_idx));
                        s_idx++;
                        s_beats--;
                        s_gap = (gap_cfg == 0) ? 0 : gap_cfg - 1;
                    end else if (s_gap > 0) begin
                        s_gap--;
                    end
                end
                avm_waitrequest = 1'b1;
                if (avm_read) begin
                    if (!s_seen) begin s_seen = 1'b1; s_wait = wait_cfg; end
                    if (s_wait > 0) begin
                        s_wait--;
                    end else begin
                        avm_waitrequest = 1'b0;
                        s_acc = 1'b1;
                        s_acc_addr = avm_address;
                        s_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        logic prev_rw, prev_fs, prev_clr, prev_other_full;
        logic [25:0] prev_addr;
        int rd_cyc;
        prev_rw = 1'b0; prev_fs = 1'b0; prev_clr = 1'b0; prev_other_full = 1'b0;
        prev_addr = '0; rd_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_rw = 1'b0; prev_fs = 1'b0; prev_clr = 1'b0; rd_cyc = 0;
            end else begin
                if (prev_fs) check("read_after_start", 64'(avm_read), 64'(1));
                if (prev_clr && prev_other_full && fifo_space >= 10'd32)
                    check("no_gap_start", 64'(frame_start), 64'(1));
                if (avm_read && prev_rw) check("addr_hold", 64'(avm_address), 64'(prev_addr));
                if (avm_read) rd_cyc++;
                if (avm_read && !avm_waitrequest) begin
                    check("burstcount", 64'(avm_burstcount), 64'(BL));
                    check("read_cycles", 64'(rd_cyc), 64'(wait_cfg + 1));
                    rd_cyc = 0;
                    if (exp_addr.size() == 0) unexpected("burst_addr", 64'(avm_address));
                    else check("burst_addr", 64'(avm_address), 64'(exp_addr.pop_front()));
                end
                if (fifo_wr) begin
                    wr_count++;
                    if (exp_data.size() == 0) unexpected("fifo_data", 64'(fifo_wr_data));
                    else check("fifo_data", 64'(fifo_wr_data), 64'(exp_data.pop_front()));
                end
                if (clear_buffer0 || clear_buffer1) begin
                    if (exp_clear.size() == 0) unexpected("clear", 64'({clear_buffer1, clear_buffer0}));
                    else check("clear", 64'({clear_buffer1, clear_buffer0}), 64'(exp_clear.pop_front()));
                end
                if (frame_start) begin
                    if (exp_fs.size() == 0) unexpected("frame_start_buf", 64'(cur_buffer));
                    else check("frame_start_buf", 64'(cur_buffer), 64'(exp_fs.pop_front()));
                end
                prev_rw = avm_read && avm_waitrequest;
                prev_addr = avm_address;
                prev_fs = frame_start;
                prev_clr = clear_buffer0 || clear_buffer1;
                prev_other_full = cur_buffer ? !buffer0_empty : !buffer1_empty;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_addr.size() + exp_data.size() + exp_clear.size() + exp_fs.size()) != 0
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_complete", 64'(n < budget), 64'(1));
        repeat (2) @(negedge clk);
        check("cur_buffer", 64'(cur_buffer), 64'(ref_cur));
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_avm_read"}, 64'(avm_read), 64'(0));
        check({tag, "_avm_address"}, 64'(avm_address), 64'(0));
        check({tag, "_fifo_wr"}, 64'(fifo_wr), 64'(0));
        check({tag, "_fifo_wr_data"}, 64'(fifo_wr_data), 64'(0));
        check({tag, "_frame_start"}, 64'(frame_start), 64'(0));
        check({tag, "_clear"}, 64'({clear_buffer1, clear_buffer0}), 64'(0));
        check({tag, "_cur_buffer"}, 64'(cur_buffer), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [25:0] off;
        logic bad;
        int base, n;
        reset_n = 1'b0;
        buffer0_offset = '0;
        buffer1_offset = '0;
        fifo_space = 10'd256;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_burstcount", 64'(avm_burstcount), 64'(BL));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Single frame from buffer 0; offset changed mid-frame must be ignored.
        @(posedge clk); #1;
        buffer0_offset = 26'h100;
        push_frame(1'b0, 26'h100);
        fill0_req++;
        base = wr_count; n = 0;
        while (wr_count == base && n < 200) begin @(posedge clk); n++; end
        #1 buffer0_offset = 26'h2AAAAAA;
        wait_done(2000);

        // Ping-pong with address wrap on buffer 1, buffer 0 already full.
        buffer1_offset = 26'h3FFFFF0;
        buffer0_offset = 26'h0002000;
        push_frame(1'b1, 26'h3FFFFF0);
        push_frame(1'b0, 26'h0002000);
        fill1_req++;
        fill0_req++;
        wait_done(4000);

        // Backpressure: 7 waitrequest cycles per burst.
        wait_cfg = 7;
        off = 26'($urandom);
        buffer1_offset = off;
        push_frame(1'b1, off);
        fill1_req++;
        wait_done(2000);
        wait_cfg = 0;

        // FIFO throttle: 31 free entries hold the request off.
        fifo_space = 10'd31;
        off = 26'($urandom);
        buffer0_offset = off;
        push_frame(1'b0, off);
        fill0_req++;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bad = bad | avm_read | busy | frame_start;
        end
        check("throttle_hold", 64'(bad), 64'(0));
        @(posedge clk); #1;
        fifo_space = 10'd32;
        @(negedge clk);
        check("throttle_start", 64'(frame_start), 64'(1));
        @(negedge clk);
        check("throttle_release", 64'(avm_read), 64'(1));
        wait_done(2000);
        fifo_space = 10'd256;

        // Sparse readdatavalid, one beat every third cycle.
        gap_cfg = 3;
        off = 26'($urandom);
        buffer1_offset = off;
        push_frame(1'b1, off);
        fill1_req++;
        wait_done(3000);
        gap_cfg = 1;

        // Reset in the middle of the first burst, then restart from offset0.
        off = 26'($urandom);
        buffer0_offset = off;
        push_frame(1'b0, off);
        fill0_req++;
        base = wr_count; n = 0;
        while (wr_count - base < 10 && n < 1000) begin @(posedge clk); n++; end
        check("reach_beat10", 64'(n < 1000), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_addr.delete();
        exp_data.delete();
        exp_clear.delete();
        exp_fs.delete();
        ref_cur = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bad = bad | clear_buffer0 | clear_buffer1;
        end
        check("no_clear_in_reset", 64'(bad), 64'(0));
        push_frame(1'b0, off);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_done(2000);

        // Randomized frames: random bases, wait states and valid spacing.
        for (int r = 0; r < 4; r++) begin
            wait_cfg = $urandom_range(0, 3);
            gap_cfg = $urandom_range(0, 3);
            off = 26'($urandom);
            if (ref_cur) begin
                buffer1_offset = off;
                push_frame(1'b1, off);
                fill1_req++;
            end else begin
                buffer0_offset = off;
                push_frame(1'b0, off);
                fill0_req++;
            end
            wait_done(3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
